// File: rtl/rw_arbiter_pkg.sv
// Shared definitions for the read/write state arbiter: default sizes,
// data-word and requester-index types, and the 2-way write mux used by the
// stateful atoms.
package rw_pkg;

  localparam int DEF_COUNT_WIDTH = 32;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_IDX_WIDTH   = $clog2(DEF_NUM_REQ);

  typedef logic [DEF_COUNT_WIDTH-1:0] word_t;
  typedef logic [DEF_IDX_WIDTH-1:0]   req_idx_t;

  // Write-source select: sel=0 picks the constant, sel=1 picks the packet field.
  function automatic word_t mux2(input logic sel, input word_t constant, input word_t pkt);
    return sel ? pkt : constant;
  endfunction

endpackage

// File: rtl/rw_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter. Scans the request vector starting at
// the pointer, ascending with wrap, and grants the first set bit. A pointer
// code outside 0..NUM_REQ-1 is treated as 0 so an out-of-range value can
// never produce an out-of-range grant.
module rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [IDX_WIDTH-1:0] gnt_idx,
  output logic                 gnt_any
);

  // One extra bit so ptr + offset never overflows before the wrap.
  localparam logic [IDX_WIDTH:0] NUM_REQ_X = (IDX_WIDTH+1)'(NUM_REQ);

  logic [IDX_WIDTH:0]   base_x;
  logic [IDX_WIDTH:0]   cand_x;
  logic [IDX_WIDTH-1:0] cand_idx;
  logic                 found;
  logic [IDX_WIDTH-1:0] found_idx;

  // Priority scan from the pointer; first requesting index wins.
  always_comb begin
    base_x    = ({1'b0, ptr} < NUM_REQ_X) ? {1'b0, ptr} : '0;
    cand_x    = '0;
    cand_idx  = '0;
    found     = 1'b0;
    found_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_x = base_x + (IDX_WIDTH+1)'(k);
      if (cand_x >= NUM_REQ_X) begin
        cand_x = cand_x - NUM_REQ_X;
      end
      cand_idx = cand_x[IDX_WIDTH-1:0];
      if (!found && req[cand_idx]) begin
        found     = 1'b1;
        found_idx = cand_idx;
      end
    end
  end

  assign gnt_any = found;
  assign gnt_idx = found_idx;

  // One-hot decode of the winning index.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_decode
      assign gnt[gi] = found && (found_idx == IDX_WIDTH'(gi));
    end
  endgenerate

endmodule

// File: rtl/rw_arbiter.sv
// Shared read/write state register arbitrated between NUM_REQ pipelines.
// Each cycle at most one requester gets an atomic read-then-write; the old
// register value returns one cycle later tagged with the requester index.
// Also owns the write-constant configuration register.
module rw_arbiter
  import rw_pkg::*;
#(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int IDX_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i__cfg_valid,
  input  logic [COUNT_WIDTH-1:0]         i__cfg_constant,
  input  logic [NUM_REQ-1:0]             i__req,
  input  logic [NUM_REQ-1:0]             i__sel,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] i__pkt_1,
  output logic [NUM_REQ-1:0]             o__gnt,
  output logic                           o__rsp_valid,
  output logic [IDX_WIDTH-1:0]           o__rsp_id,
  output logic [COUNT_WIDTH-1:0]         o__read,
  output logic [COUNT_WIDTH-1:0]         o__state
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REQ - 1);

  logic [IDX_WIDTH-1:0]   ptr_reg;
  logic [COUNT_WIDTH-1:0] state_reg;
  logic [COUNT_WIDTH-1:0] const_reg;
  logic                   rsp_valid_reg;
  logic [IDX_WIDTH-1:0]   rsp_id_reg;
  logic [COUNT_WIDTH-1:0] read_reg;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IDX_WIDTH-1:0]   gnt_idx;
  logic                   gnt_any;
  logic                   sel_g;
  logic [COUNT_WIDTH-1:0] pkt_g;
  logic [COUNT_WIDTH-1:0] write_next;
  logic [IDX_WIDTH-1:0]   ptr_next;

  logic [COUNT_WIDTH-1:0] pkt_arr [NUM_REQ];

  // Unpack the flattened packet fields, requester k at [k*W +: W].
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign pkt_arr[gi] = i__pkt_1[gi*COUNT_WIDTH +: COUNT_WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr (
    .req     (i__req),
    .ptr     (ptr_reg),
    .gnt     (arb_gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // sel and pkt only matter for the winning requester in the grant cycle.
  assign sel_g = i__sel[gnt_idx];
  assign pkt_g = pkt_arr[gnt_idx];

  // The package mux is sized for the default word; other widths use an
  // equivalent inline select.
  generate
    if (COUNT_WIDTH == DEF_COUNT_WIDTH) begin : g_pkg_mux
      assign write_next = mux2(sel_g, const_reg, pkt_g);
    end else begin : g_local_mux
      assign write_next = sel_g ? pkt_g : const_reg;
    end
  endgenerate

  // Pointer moves to one past the winner, wrapping at NUM_REQ-1.
  assign ptr_next = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_WIDTH'(1);

  // Grant is suppressed while reset is held.
  assign o__gnt = rst ? '0 : arb_gnt;

  // Constant register: a same-cycle grant still sees the old constant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      const_reg <= '0;
    end else if (i__cfg_valid) begin
      const_reg <= i__cfg_constant;
    end
  end

  // Atomic read-then-write of the shared state plus pointer advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
      ptr_reg   <= '0;
    end else if (gnt_any) begin
      state_reg <= write_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Response stage: old value and owner index; data holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      read_reg      <= '0;
    end else if (gnt_any) begin
      rsp_valid_reg <= 1'b1;
      rsp_id_reg    <= gnt_idx;
      read_reg      <= state_reg;
    end else begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign o__rsp_valid = rsp_valid_reg;
  assign o__rsp_id    = rsp_id_reg;
  assign o__read      = read_reg;
  assign o__state     = state_reg;

endmodule

// File: tb/tb_rw_arbiter.sv
// Directed bench for rw_arbiter (NUM_REQ=4, COUNT_WIDTH=32).
module tb_rw_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic           cfg_valid;
  logic [W-1:0]   cfg_constant;
  logic [N-1:0]   req;
  logic [N-1:0]   sel;
  logic [N*W-1:0] pkt;
  logic [N-1:0]   gnt;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rd;
  logic [W-1:0]   state;

  int vectors;
  int miscompares;

  rw_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .i__cfg_valid    (cfg_valid),
    .i__cfg_constant (cfg_constant),
    .i__req          (req),
    .i__sel          (sel),
    .i__pkt_1        (pkt),
    .o__gnt          (gnt),
    .o__rsp_valid    (rsp_valid),
    .o__rsp_id       (rsp_id),
    .o__read         (rd),
    .o__state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int k, input logic [W-1:0] v);
    pkt[k*W +: W] = v;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [W-1:0] r,
                         input logic [W-1:0] s);
    chk({tag, "_valid"}, W'(rsp_valid), W'(1));
    chk({tag, "_id"},    W'(rsp_id),    W'(id));
    chk({tag, "_read"},  rd,            r);
    chk({tag, "_state"}, state,         s);
    $display("txn %s: id=%0d read=0x%0h state=0x%0h", tag, rsp_id, rd, state);
  endtask

  initial begin
    logic [N-1:0] rr_gnt [6];
    logic [W-1:0] rr_read [6];
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    cfg_valid    = 1'b0;
    cfg_constant = '0;
    req          = 4'b1111;
    sel          = '0;
    pkt          = '0;

    // 1. Reset holds grant off and clears state.
    #3;
    chk("rst_gnt",   W'(gnt),       W'(0));
    chk("rst_valid", W'(rsp_valid), W'(0));
    chk("rst_state", state,         W'(0));
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_gnt", W'(gnt), W'(4'b0001));
    req = '0;
    tick();
    chk("idle_valid", W'(rsp_valid), W'(0));

    // 2. Single packet write from requester 2.
    req = 4'b0100;
    sel = 4'b0100;
    set_pkt(2, 32'h0000_00AA);
    #1;
    chk("single_gnt", W'(gnt), W'(4'b0100));
    tick();
    req = '0;
    chk_rsp("single", 2'd2, 32'h0, 32'hAA);

    // Re-establish a clean pointer/state for the round-robin run.
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    chk("rst2_state", state, W'(0));

    // 3. Round robin with all requesters, pkt[k]=k+1.
    rr_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    rr_read = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd1};
    for (int k = 0; k < N; k++) set_pkt(k, W'(k + 1));
    sel = 4'b1111;
    req = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr%0d_gnt", c), W'(gnt), W'(rr_gnt[c]));
      tick();
      chk($sformatf("rr%0d_id", c),   W'(rsp_id), W'(c % N));
      chk($sformatf("rr%0d_read", c), rd,         rr_read[c]);
      $display("txn rr%0d: id=%0d read=0x%0h state=0x%0h", c, rsp_id, rd, state);
    end
    req = '0;
    chk("rr_state", state, W'(2));   // pointer now 2

    // 4. Config collision: grant sees old constant.
    cfg_valid = 1'b1;
    cfg_constant = 32'd5;
    tick();
    cfg_constant = 32'd9;
    req = 4'b0001;
    sel = 4'b0000;
    #1;
    chk("cfg1_gnt", W'(gnt), W'(4'b0001));
    tick();
    cfg_valid = 1'b0;
    chk_rsp("cfg1", 2'd0, 32'd2, 32'd5);
    tick();                           // pointer is 1, req[0] still wins
    req = '0;
    chk_rsp("cfg2", 2'd0, 32'd5, 32'd9);

    // 5. Pointer wrap with sparse requests. Move pointer 1 -> 3 first.
    sel = 4'b1111;
    set_pkt(1, 32'h11);
    set_pkt(2, 32'h33);
    set_pkt(3, 32'h44);
    req = 4'b0100;
    tick();
    chk_rsp("ptr3", 2'd2, 32'd9, 32'h33);
    req = 4'b0010;
    #1;
    chk("wrap1_gnt", W'(gnt), W'(4'b0010));
    tick();
    chk_rsp("wrap1", 2'd1, 32'h33, 32'h11);
    req = 4'b1001;                    // pointer 2: index 3 before 0
    #1;
    chk("wrap2_gnt", W'(gnt), W'(4'b1000));
    tick();
    chk_rsp("wrap2", 2'd3, 32'h11, 32'h44);
    req = 4'b1111;                    // pointer should be back at 0
    #1;
    chk("wrap3_gnt", W'(gnt), W'(4'b0001));
    req = '0;
    tick();
    chk("hold_valid", W'(rsp_valid), W'(0));
    chk("hold_id",    W'(rsp_id),    W'(3));
    chk("hold_read",  rd,            W'(32'h11));
    chk("hold_state", state,         W'(32'h44));

    // 6. Asynchronous reset between edges drops the in-flight response.
    req = 4'b0001;
    set_pkt(0, 32'h77);
    tick();
    chk_rsp("pre_arst", 2'd0, 32'h44, 32'h77);
    req = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", W'(rsp_valid), W'(0));
    chk("arst_read",  rd,            W'(0));
    chk("arst_state", state,         W'(0));
    chk("arst_gnt",   W'(gnt),       W'(0));
    rst = 1'b0;
    req = 4'b0110;
    #1;
    chk("arst_first_gnt", W'(gnt), W'(4'b0010));
    tick();
    req = '0;
    chk("arst_first_id", W'(rsp_id), W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rw_arbiter.md
Name: rw_arbiter

Overview:
- Shares one read/write state register between NUM_REQ packet pipelines.
- Each cycle, a round-robin arbiter grants at most one requester an atomic read-then-write.
- The granted requester receives the pre-update register value one cycle later, tagged with its requester index.
- Sits between the per-pipeline stateful-atom stages and the single shared state element; it also owns the write-constant configuration.

Parameters:
- COUNT_WIDTH, 32: width of state register, packet field, constant and read data.
- NUM_REQ, 4: number of requesters, legal range 2..16.
- IDX_WIDTH, $clog2(NUM_REQ): width of the requester index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i__cfg_valid  input  1  load i__cfg_constant into the constant register.
- i__cfg_constant  input  COUNT_WIDTH  new write constant.
- i__req  input  NUM_REQ  per-requester request vector.
- i__sel  input  NUM_REQ  per-requester write select: 0 = write constant, 1 = write packet field.
- i__pkt_1  input  NUM_REQ*COUNT_WIDTH  flattened packet fields; requester k occupies bits [k*W +: W].
- o__gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as the request.
- o__rsp_valid  output  1  registered read response valid.
- o__rsp_id  output  IDX_WIDTH  index of the requester that owns the response.
- o__read  output  COUNT_WIDTH  register value before that requester's write.
- o__state  output  COUNT_WIDTH  current register value, for debug and observability.

Behaviour:
- Reset (asynchronous): the following all clear to 0:
  - state register, constant register, round-robin pointer;
  - o__rsp_valid, o__rsp_id, o__read.
  - o__gnt is forced to 0 while rst is high.
- Grant: scan i__req starting at the pointer, ascending with wrap from NUM_REQ-1 to 0.
  - The first set bit is granted; o__gnt is one-hot or all-zero.
  - The grant is purely a function of i__req, the pointer and rst; no dependence on sel or pkt.
- On a clock edge with a grant g:
  - state <= (i__sel[g] ? pkt[g] : constant)
  - o__read <= state (old value); o__rsp_id <= g; o__rsp_valid <= 1
  - pointer <= (g == NUM_REQ-1) ? 0 : g+1
- On a clock edge without any request:
  - o__rsp_valid <= 0.
  - o__read and o__rsp_id hold their values; state and pointer unchanged.
- Latency: the write is visible on o__state one cycle after the grant cycle. The response arrives one cycle after the grant.
- Back-to-back grants: each response's o__read equals the write of the previous grant. No read-after-write hazard exists because reads and writes are serialized through one register.
- Requester protocol:
  - A requester holds req until it sees its gnt bit.
  - Dropping req before grant is legal and leaves no residual state.
  - sel and pkt are sampled only in the grant cycle.
- Configuration:
  - When i__cfg_valid is high, constant <= i__cfg_constant at the edge.
  - A grant in the same cycle uses the OLD constant; the new constant applies from the next cycle.
- Fairness: with all requesters continuously asserted, the grant order is strictly 0,1,…,NUM_REQ-1,0,… and no requester waits more than NUM_REQ-1 cycles.
- Non-power-of-2 NUM_REQ: the pointer never exceeds NUM_REQ-1, and index decode ignores out-of-range codes.
- Reset mid-operation: any in-flight response is discarded (rsp_valid drops asynchronously). The first grant after reset release goes to the lowest requesting index.

Decomposition:
- Package rw_pkg holds:
  - COUNT_WIDTH and NUM_REQ defaults;
  - the typedef for a COUNT_WIDTH data word;
  - the typedef for the requester index;
  - the shared 2-way mux function used by the stateful atoms.
- Sub-module rr_arbiter: inputs are the request vector and pointer; outputs are the one-hot grant and the encoded index. It is purely combinational. The parent owns the pointer register, state register, constant register and response stage.

Test Plan:
1. Reset check: assert rst with i__req=4'b1111 -> o__gnt=0, rsp_valid=0, o__state=0. After release, the first grant goes to index 0.
2. Single packet write: req[2]=1, sel[2]=1, pkt[2]=0x0000_00AA -> gnt=4'b0100. Next cycle: rsp_valid=1, rsp_id=2, o__read=0, o__state=0xAA.
3. Round robin: all four requesters assert for 6 cycles, with pkt[k]=k+1 and sel=1 -> grants 0,1,2,3,0,1. The o__read sequence is 0,1,2,3,4,1.
4. Config collision: constant=5, then cfg_valid with constant 9 in the same cycle as a grant with sel=0 -> state=5. The next sel=0 grant gives state=9.
5. Pointer wrap with sparse requests: pointer at 3 with req=4'b0010 -> gnt=4'b0010, and the pointer becomes 2. Then req=4'b1001 -> gnt=4'b1000, and the pointer becomes 0.
6. Asynchronous reset mid-stream: assert rst between clock edges while rsp_valid=1 -> rsp_valid, o__read and o__state go to 0 immediately, before the next clock edge.
